// File: rtl/fe_tx_pkg.sv
// Shared definitions for the TX sample-RAM read arbiter: EOP id bit,
// arbiter state encoding and the round-robin search helper.
package fe_tx_pkg;

  localparam int ID_EOP_BIT = 0;
  localparam int MAX_REQ    = 8;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_t;

  // First set bit of req strictly after ptr, searching cyclically over num entries.
  function automatic logic [2:0] rr_next(input logic [MAX_REQ-1:0] req,
                                         input logic [2:0]         ptr,
                                         input int                 num);
    logic [2:0] pick;
    logic       found;
    int         idx;
    pick  = ptr;
    found = 1'b0;
    for (int i = 1; i <= MAX_REQ; i++) begin
      idx = (int'(ptr) + i) % num;
      if (!found && (i <= num) && req[idx]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/fe_route_fifo.sv
// In-order routing FIFO: remembers which requester issued each outstanding read.
module fe_route_fifo #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_push_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_count   = r_count;

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  // DEPTH is a power of two, so pointer overflow is the wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/fe_tx_rd_arbiter.sv
// Round-robin burst arbiter sharing one TX sample-RAM read port between frontends,
// with an in-order routing FIFO steering read responses back to their issuer.
//
// state    | meaning
// ST_IDLE  | no grant held; pick next enabled requester after rr_ptr
// ST_BURST | grant held; forward beats of the granted requester until EOP
module fe_tx_rd_arbiter
  import fe_tx_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int ADDR_WIDTH  = 15,
  parameter int ID_WIDTH    = 3,
  parameter int DATA_WIDTH  = 64,
  parameter int ROUTE_DEPTH = 16,
  parameter int BURST_LOCK  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            cfg_req_en,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] s_araddr,
  input  logic [NUM_REQ-1:0]            s_arvalid,
  output logic [NUM_REQ-1:0]            s_arready,
  input  logic [NUM_REQ*ID_WIDTH-1:0]   s_arid,
  output logic [DATA_WIDTH-1:0]         s_rdata,
  output logic [NUM_REQ-1:0]            s_rvalid,
  output logic [ID_WIDTH-1:0]           s_rid,
  input  logic [NUM_REQ-1:0]            s_rready,
  output logic [ADDR_WIDTH-1:0]         m_araddr,
  output logic                          m_arvalid,
  input  logic                          m_arready,
  output logic [ID_WIDTH-1:0]           m_arid,
  input  logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic                          m_rvalid,
  input  logic [ID_WIDTH-1:0]           m_rid,
  output logic                          m_rready,
  output logic [$clog2(ROUTE_DEPTH):0]  stat_outstanding,
  output logic                          err_orphan
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   w_grant_nxt;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [IDX_W-1:0]   w_rr_ptr_nxt;
  logic               r_err_orphan;

  logic [NUM_REQ-1:0] w_req;
  logic [2:0]         w_rr_pick;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [IDX_W-1:0]   w_head;

  assign w_req     = s_arvalid & cfg_req_en;
  assign w_rr_pick = rr_next(MAX_REQ'(w_req), 3'(r_rr_ptr), NUM_REQ);

  assign m_araddr  = s_araddr[r_grant*ADDR_WIDTH +: ADDR_WIDTH];
  assign m_arid    = s_arid[r_grant*ID_WIDTH +: ID_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_rr_ptr <= IDX_W'(NUM_REQ - 1);
    end else begin
      r_state  <= w_state_nxt;
      r_grant  <= w_grant_nxt;
      r_rr_ptr <= w_rr_ptr_nxt;
    end
  end

  // cfg_req_en only gates new grants; a granted requester runs its burst to EOP.
  always_comb begin
    w_state_nxt  = r_state;
    w_grant_nxt  = r_grant;
    w_rr_ptr_nxt = r_rr_ptr;
    m_arvalid    = 1'b0;
    s_arready    = '0;
    w_push       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_grant_nxt = IDX_W'(w_rr_pick);
          w_state_nxt = ST_BURST;
        end
      end
      ST_BURST: begin
        m_arvalid          = s_arvalid[r_grant] & ~w_full;
        s_arready[r_grant] = m_arready & ~w_full;
        if (m_arvalid && m_arready) begin
          w_push = 1'b1;
          if (m_arid[ID_EOP_BIT] || (BURST_LOCK == 0)) begin
            w_rr_ptr_nxt = r_grant;
            w_state_nxt  = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  fe_route_fifo #(
    .WIDTH (IDX_W),
    .DEPTH (ROUTE_DEPTH)
  ) u_route_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (r_grant),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_count     (stat_outstanding),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  assign s_rdata = m_rdata;
  assign s_rid   = m_rid;

  // With no routing entry the beat is accepted and dropped so the RAM side never stalls.
  always_comb begin
    s_rvalid = '0;
    m_rready = 1'b0;
    if (w_empty) begin
      m_rready = m_rvalid;
    end else begin
      m_rready         = s_rready[w_head];
      s_rvalid[w_head] = m_rvalid;
    end
  end

  assign w_pop = m_rvalid & m_rready & ~w_empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_err_orphan <= 1'b0;
    else if (m_rvalid && w_empty) r_err_orphan <= 1'b1;
  end

  assign err_orphan = r_err_orphan;

endmodule
